hdmi_period_scheduler: RTL and testbench

- Per-pixel-clock sequencer that decides which HDMI period type the three TMDS channel encoders emit.
- Period types: control, video preamble, video guard band, active video, data-island preamble, data-island guard band, packet data.
- Sits between the 640x480 timing counters and the encoders/packet serializer on the pixclk domain.
- Arbitrates horizontal blanking between control periods and up to MAX_PKTS 32-clock data-island packets per line.

---
 rtl/hdmi_period_scheduler_pkg.sv | 55 +++++
 rtl/hdmi_period_scheduler_if.sv | 28 ++
 rtl/hdmi_period_scheduler.sv | 202 ++++++++++++++++++++
 tb/tb_hdmi_period_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_period_scheduler_pkg.sv
// Shared types and constants for the HDMI period scheduler and the
// encoder blocks that consume its mode/word_idx outputs.
package hdmi_pkg;

    // Period code seen by the TMDS encoders and packet serializer
    typedef enum logic [2:0] {
        CTRL    = 3'd0,
        VID_PRE = 3'd1,
        VID_GB  = 3'd2,
        VIDEO   = 3'd3,
        DI_PRE  = 3'd4,
        DI_GB   = 3'd5,
        DI_DATA = 3'd6
    } mode_t;

    // Internal sequencer states; leading and trailing island guard bands
    // are distinct so the FSM knows where to go next
    typedef enum logic [2:0] {
        ST_CTRL        = 3'd0,
        ST_VID_PRE     = 3'd1,
        ST_VID_GB      = 3'd2,
        ST_VIDEO       = 3'd3,
        ST_DI_PRE      = 3'd4,
        ST_DI_GB_LEAD  = 3'd5,
        ST_DI_DATA     = 3'd6,
        ST_DI_GB_TRAIL = 3'd7
    } state_t;

    // CTL3..CTL0 preamble codes
    localparam logic [3:0] CTL_VID_PRE = 4'b0001;
    localparam logic [3:0] CTL_DI_PRE  = 4'b0101;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PKT_LEN      = 32;
    localparam int MIN_CTRL     = 12;

    // Width of the shared length counter (must hold PKT_LEN-1)
    localparam int CNT_W = 5;

    // Collapse internal states onto the period code
    function automatic mode_t state_to_mode(input state_t st);
        case (st)
            ST_VID_PRE:     return VID_PRE;
            ST_VID_GB:      return VID_GB;
            ST_VIDEO:       return VIDEO;
            ST_DI_PRE:      return DI_PRE;
            ST_DI_GB_LEAD:  return DI_GB;
            ST_DI_DATA:     return DI_DATA;
            ST_DI_GB_TRAIL: return DI_GB;
            default:        return CTRL;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_period_scheduler_if.sv
// Bundle between timing generator / packet source (master) and the
// period scheduler (slave).
interface hdmi_period_scheduler_if
    import hdmi_pkg::*;
();
    logic [9:0] counter_x;
    logic [9:0] counter_y;
    logic       hsync_in;
    logic       vsync_in;
    logic       pkt_valid;
    logic       pkt_ready;
    logic [4:0] word_idx;
    mode_t      mode;
    logic [3:0] ctl;
    logic       de;
    logic       hsync_out;
    logic       vsync_out;

    modport master (
        output counter_x, counter_y, hsync_in, vsync_in, pkt_valid,
        input  pkt_ready, word_idx, mode, ctl, de, hsync_out, vsync_out
    );

    modport slave (
        input  counter_x, counter_y, hsync_in, vsync_in, pkt_valid,
        output pkt_ready, word_idx, mode, ctl, de, hsync_out, vsync_out
    );
endinterface

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer: decides control / preamble / guard /
// video / data-island periods from the raster position. All outputs are
// registered, so the values for counter_x=N appear one clock later.
module hdmi_period_scheduler
    import hdmi_pkg::*;
#(
    parameter int H_ACTIVE     = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_ACTIVE     = 480,
    parameter int V_TOTAL      = 525,
    parameter int DI_START_OFS = 12,
    parameter int MAX_PKTS     = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    hdmi_period_scheduler_if.slave  bus
);

    localparam int PKT_CNT_W  = $clog2(MAX_PKTS + 1);
    localparam int ISLAND_END = H_ACTIVE + DI_START_OFS + PREAMBLE_LEN
                              + 2 * GUARD_LEN + MAX_PKTS * PKT_LEN;

    localparam logic [9:0] X_VID_PRE = 10'(H_TOTAL - 10);
    localparam logic [9:0] X_VID_END = 10'(H_ACTIVE);
    localparam logic [9:0] X_DI      = 10'(H_ACTIVE + DI_START_OFS);
    localparam logic [9:0] X_LIMIT   = 10'(H_TOTAL);
    localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] Y_ACT     = 10'(V_ACTIVE);

    // The longest island plus its minimum control gap must finish before
    // the video preamble of the next line begins.
    if (ISLAND_END + MIN_CTRL > H_TOTAL - 10) begin : g_island_fit
        $error("data island does not fit in horizontal blanking");
    end

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PKT_CNT_W-1:0] pkts_q, pkts_d;

    mode_t                mode_q, mode_d;
    logic [3:0]           ctl_q, ctl_d;
    logic                 de_q, de_d;
    logic                 pkt_ready_q, pkt_ready_d;
    logic [CNT_W-1:0]     word_idx_q, word_idx_d;
    logic                 hsync_q, vsync_q;

    logic [9:0]           next_y;
    logic                 lead_video;

    assign next_y     = (bus.counter_y == Y_LAST) ? 10'd0 : bus.counter_y + 10'd1;
    assign lead_video = (next_y < Y_ACT);

    // State, length counter and packet count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CTRL;
            cnt_q   <= '0;
            pkts_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pkts_q  <= pkts_d;
        end
    end

    // Next-state logic: period for the pixel currently on counter_x
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pkts_d  = pkts_q;
        if (bus.counter_x >= X_LIMIT) begin
            state_d = ST_CTRL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_CTRL: begin
                    if (bus.counter_x == X_VID_PRE && lead_video) begin
                        state_d = ST_VID_PRE;
                        cnt_d   = CNT_W'(PREAMBLE_LEN - 1);
                    end else if (bus.counter_x == X_DI && bus.pkt_valid) begin
                        state_d = ST_DI_PRE;
                        cnt_d   = CNT_W'(PREAMBLE_LEN - 1);
                        pkts_d  = '0;
                    end
                end
                ST_VID_PRE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_VID_GB;
                        cnt_d   = CNT_W'(GUARD_LEN - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_VID_GB: begin
                    if (cnt_q == '0) begin
                        state_d = ST_VIDEO;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_VIDEO: begin
                    if (bus.counter_x == X_VID_END) begin
                        state_d = ST_CTRL;
                    end
                end
                ST_DI_PRE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DI_GB_LEAD;
                        cnt_d   = CNT_W'(GUARD_LEN - 1);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DI_GB_LEAD: begin
                    if (cnt_q == '0) begin
                        state_d = ST_DI_DATA;
                        cnt_d   = CNT_W'(PKT_LEN - 1);
                        pkts_d  = pkts_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DI_DATA: begin
                    // A committed packet always runs to completion; the
                    // continue/stop decision is made only at its boundary.
                    if (cnt_q == '0) begin
                        if (bus.pkt_valid && pkts_q < PKT_CNT_W'(MAX_PKTS)) begin
                            cnt_d  = CNT_W'(PKT_LEN - 1);
                            pkts_d = pkts_q + 1'b1;
                        end else begin
                            state_d = ST_DI_GB_TRAIL;
                            cnt_d   = CNT_W'(GUARD_LEN - 1);
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DI_GB_TRAIL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_CTRL;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_CTRL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up
    // with the pixel that produced them
    always_comb begin
        mode_d      = state_to_mode(state_d);
        ctl_d       = 4'b0000;
        de_d        = 1'b0;
        pkt_ready_d = 1'b0;
        word_idx_d  = '0;
        case (state_d)
            ST_VID_PRE: ctl_d = CTL_VID_PRE;
            ST_DI_PRE:  ctl_d = CTL_DI_PRE;
            ST_VIDEO:   de_d  = 1'b1;
            ST_DI_DATA: begin
                word_idx_d  = CNT_W'(PKT_LEN - 1) - cnt_d;
                pkt_ready_d = (cnt_d == CNT_W'(PKT_LEN - 1));
            end
            default: ;
        endcase
    end

    // Output registers, including the one-clock sync delay
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= CTRL;
            ctl_q       <= 4'b0000;
            de_q        <= 1'b0;
            pkt_ready_q <= 1'b0;
            word_idx_q  <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            ctl_q       <= ctl_d;
            de_q        <= de_d;
            pkt_ready_q <= pkt_ready_d;
            word_idx_q  <= word_idx_d;
            hsync_q     <= bus.hsync_in;
            vsync_q     <= bus.vsync_in;
        end
    end

    assign bus.mode      = mode_q;
    assign bus.ctl       = ctl_q;
    assign bus.de        = de_q;
    assign bus.pkt_ready = pkt_ready_q;
    assign bus.word_idx  = word_idx_q;
    assign bus.hsync_out = hsync_q;
    assign bus.vsync_out = vsync_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Self-checking bench for hdmi_period_scheduler: per line, the expected
// period map is built from the raster rules, then the line is driven.
module tb_hdmi_period_scheduler;
    import hdmi_pkg::*;

    localparam int H_ACT  = 640;
    localparam int H_TOT  = 800;
    localparam int V_ACT  = 480;
    localparam int V_TOT  = 525;
    localparam int DI_X   = 652;
    localparam int MAXP   = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hdmi_period_scheduler_if bus();

    hdmi_period_scheduler #(
        .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT),
        .DI_START_OFS(12), .MAX_PKTS(MAXP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    mode_t      e_mode [H_TOT];
    logic [3:0] e_ctl  [H_TOT];
    bit         e_de   [H_TOT];
    bit         e_rdy  [H_TOT];
    int         e_idx  [H_TOT];
    bit         pv     [H_TOT];
    bit         hs     [H_TOT];
    bit         vs     [H_TOT];
    bit         prev_lead;

    // pat: 0 never valid, 1 always valid, 2 random per clock,
    //      3 valid only at the island start, 4 valid from one clock late
    task automatic run_line(input int y, input int pat, input int rx);
        int ny, s, n;
        bit lead;
        for (int x = 0; x < H_TOT; x++) begin
            case (pat)
                0:       pv[x] = 1'b0;
                1:       pv[x] = 1'b1;
                3:       pv[x] = (x == DI_X);
                4:       pv[x] = (x >= DI_X + 1);
                default: pv[x] = 1'($urandom_range(0, 1));
            endcase
            hs[x]     = 1'($urandom_range(0, 1));
            vs[x]     = 1'($urandom_range(0, 1));
            e_mode[x] = CTRL;
            e_ctl[x]  = 4'b0000;
            e_de[x]   = 1'b0;
            e_rdy[x]  = 1'b0;
            e_idx[x]  = 0;
        end
        if (prev_lead) begin
            for (int x = 0; x < H_ACT; x++) begin
                e_mode[x] = VIDEO;
                e_de[x]   = 1'b1;
            end
        end
        if (pv[DI_X]) begin
            for (int x = DI_X; x < DI_X + 8; x++) begin
                e_mode[x] = DI_PRE;
                e_ctl[x]  = 4'b0101;
            end
            e_mode[DI_X + 8] = DI_GB;
            e_mode[DI_X + 9] = DI_GB;
            s = DI_X + 10;
            n = 0;
            do begin
                for (int k = 0; k < 32; k++) begin
                    e_mode[s + k] = DI_DATA;
                    e_idx[s + k]  = k;
                end
                e_rdy[s] = 1'b1;
                n++;
                s += 32;
            end while (n < MAXP && pv[s]);
            e_mode[s]     = DI_GB;
            e_mode[s + 1] = DI_GB;
        end
        ny   = (y == V_TOT - 1) ? 0 : y + 1;
        lead = (ny < V_ACT);
        if (lead) begin
            for (int x = H_TOT - 10; x < H_TOT - 2; x++) begin
                e_mode[x] = VID_PRE;
                e_ctl[x]  = 4'b0001;
            end
            e_mode[H_TOT - 2] = VID_GB;
            e_mode[H_TOT - 1] = VID_GB;
        end
        if (rx >= 0) begin
            for (int x = rx; x < H_TOT - 10; x++) begin
                e_mode[x] = CTRL;
                e_ctl[x]  = 4'b0000;
                e_de[x]   = 1'b0;
                e_rdy[x]  = 1'b0;
                e_idx[x]  = 0;
            end
        end
        for (int x = 0; x < H_TOT; x++) begin
            @(negedge clk);
            rst           = (x == rx);
            bus.counter_x = 10'(x);
            bus.counter_y = 10'(y);
            bus.pkt_valid = pv[x];
            bus.hsync_in  = hs[x];
            bus.vsync_in  = vs[x];
            @(posedge clk);
            #1;
            chk($sformatf("mode y=%0d x=%0d", y, x), 32'(bus.mode), 32'(e_mode[x]));
            chk($sformatf("ctl y=%0d x=%0d", y, x), 32'(bus.ctl), 32'(e_ctl[x]));
            chk($sformatf("de y=%0d x=%0d", y, x), 32'(bus.de), 32'(e_de[x]));
            chk($sformatf("pkt_ready y=%0d x=%0d", y, x), 32'(bus.pkt_ready), 32'(e_rdy[x]));
            chk($sformatf("word_idx y=%0d x=%0d", y, x), 32'(bus.word_idx), 32'(e_idx[x]));
            chk($sformatf("hsync y=%0d x=%0d", y, x), 32'(bus.hsync_out), (x == rx) ? 32'd0 : 32'(hs[x]));
            chk($sformatf("vsync y=%0d x=%0d", y, x), 32'(bus.vsync_out), (x == rx) ? 32'd0 : 32'(vs[x]));
        end
        rst       = 1'b0;
        prev_lead = lead;
    endtask

    function automatic int rand_rst();
        if ($urandom_range(0, 4) == 0) return int'($urandom_range(652, 760));
        return -1;
    endfunction

    initial begin
        int hb, vb;
        rst           = 1'b1;
        bus.counter_x = 10'd700;
        bus.counter_y = 10'd10;
        bus.pkt_valid = 1'b1;
        bus.hsync_in  = 1'b1;
        bus.vsync_in  = 1'b1;
        prev_lead     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset mode", 32'(bus.mode), 32'(CTRL));
        chk("reset ctl", 32'(bus.ctl), 32'd0);
        chk("reset de", 32'(bus.de), 32'd0);
        chk("reset pkt_ready", 32'(bus.pkt_ready), 32'd0);
        chk("reset word_idx", 32'(bus.word_idx), 32'd0);
        chk("reset hsync", 32'(bus.hsync_out), 32'd0);
        chk("reset vsync", 32'(bus.vsync_out), 32'd0);

        run_line(477, 2, -1);
        run_line(478, 1, -1);
        run_line(479, 0, -1);
        run_line(480, 1, -1);
        run_line(481, 2, -1);
        run_line(522, 2, -1);
        run_line(523, 2, -1);
        run_line(524, 1, -1);
        for (int y = 0; y < 10; y++) run_line(y, int'($urandom_range(0, 4)), rand_rst());
        run_line(10, 1, -1);
        run_line(11, 3, -1);
        run_line(12, 4, -1);
        run_line(13, 1, -1);
        run_line(14, 1, 670);
        run_line(15, 1, -1);
        for (int y = 16; y < 30; y++) run_line(y, int'($urandom_range(0, 4)), rand_rst());

        // Counters outside the raster: control period, syncs still pass
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hb            = int'($urandom_range(0, 1));
            vb            = int'($urandom_range(0, 1));
            bus.counter_x = 10'($urandom_range(H_TOT, 1023));
            bus.counter_y = 10'($urandom_range(0, 524));
            bus.pkt_valid = 1'($urandom_range(0, 1));
            bus.hsync_in  = 1'(hb);
            bus.vsync_in  = 1'(vb);
            @(posedge clk);
            #1;
            chk($sformatf("oor mode i=%0d", i), 32'(bus.mode), 32'(CTRL));
            chk($sformatf("oor ctl i=%0d", i), 32'(bus.ctl), 32'd0);
            chk($sformatf("oor de i=%0d", i), 32'(bus.de), 32'd0);
            chk($sformatf("oor pkt_ready i=%0d", i), 32'(bus.pkt_ready), 32'd0);
            chk($sformatf("oor hsync i=%0d", i), 32'(bus.hsync_out), 32'(hb));
            chk($sformatf("oor vsync i=%0d", i), 32'(bus.vsync_out), 32'(vb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
